// File: rtl/nrisc_bus_bridge.sv
// Peripheral bus bridge: one four-phase req/ack access at a time; NRISC_BUSBRIDGE_TIMEOUT_EN adds abort of unacknowledged requests.
// Registered outputs; req one edge after start, done one edge after ack falls; starts while busy are dropped.
module nrisc_bus_bridge #(
  parameter int N_DData = 8,
  parameter int TAM     = 16,
  parameter int TIMEOUT = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_DData-1:0] BRIDGE_addr,
  input  logic [TAM-1:0]     BRIDGE_wdata,
  input  logic               BRIDGE_start_wr,
  input  logic               BRIDGE_start_rd,
  output logic [TAM-1:0]     BRIDGE_rdata,
  output logic               BRIDGE_busy,
  output logic               BRIDGE_done,
  output logic               BRIDGE_err,
  output logic [N_DData-1:0] PBUS_addr,
  output logic [TAM-1:0]     PBUS_wdata,
  output logic               PBUS_we,
  output logic               PBUS_req,
  input  logic               PBUS_ack,
  input  logic [TAM-1:0]     PBUS_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RELEASE} state_t;

  state_t             state_q, state_nx;
  logic [N_DData-1:0] addr_q, addr_nx;
  logic [TAM-1:0]     wdata_q, wdata_nx;
  logic [TAM-1:0]     rdata_q, rdata_nx;
  logic               we_q, we_nx;
  logic               req_q, req_nx;
  logic               busy_q, busy_nx;
  logic               done_q, done_nx;

`ifdef NRISC_BUSBRIDGE_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] cnt_q, cnt_nx;
  logic       err_q, err_nx;
`endif

  always_comb begin
    state_nx = state_q;
    addr_nx  = addr_q;
    wdata_nx = wdata_q;
    rdata_nx = rdata_q;
    we_nx    = we_q;
    req_nx   = req_q;
    busy_nx  = busy_q;
    done_nx  = 1'b0;
`ifdef NRISC_BUSBRIDGE_TIMEOUT_EN
    cnt_nx   = cnt_q;
    err_nx   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (BRIDGE_start_wr || BRIDGE_start_rd) begin
          addr_nx  = BRIDGE_addr;
          wdata_nx = BRIDGE_wdata;
          we_nx    = BRIDGE_start_wr;  // write wins a collision
          req_nx   = 1'b1;
          busy_nx  = 1'b1;
`ifdef NRISC_BUSBRIDGE_TIMEOUT_EN
          err_nx   = 1'b0;
          cnt_nx   = 8'd0;
`endif
          state_nx = ACCESS;
        end
      end
      ACCESS: begin
        if (PBUS_ack) begin
          req_nx = 1'b0;
          if (!we_q) rdata_nx = PBUS_rdata;
          state_nx = RELEASE;
        end
`ifdef NRISC_BUSBRIDGE_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          req_nx = 1'b0;
          err_nx = 1'b1;
          if (!we_q) rdata_nx = '1;
          state_nx = RELEASE;
        end else if (cnt_q != 8'hFF) begin
          cnt_nx = cnt_q + 8'd1;
        end
`endif
      end
      RELEASE: begin
        if (!PBUS_ack) begin
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_nx;
      addr_q  <= addr_nx;
      wdata_q <= wdata_nx;
      rdata_q <= rdata_nx;
      we_q    <= we_nx;
      req_q   <= req_nx;
      busy_q  <= busy_nx;
      done_q  <= done_nx;
    end
  end

`ifdef NRISC_BUSBRIDGE_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 8'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_nx;
      err_q <= err_nx;
    end
  end
  assign BRIDGE_err = err_q;
`else
  assign BRIDGE_err = 1'b0;
`endif

  assign BRIDGE_rdata = rdata_q;
  assign BRIDGE_busy  = busy_q;
  assign BRIDGE_done  = done_q;
  assign PBUS_addr    = addr_q;
  assign PBUS_wdata   = wdata_q;
  assign PBUS_we      = we_q;
  assign PBUS_req     = req_q;

endmodule

// File: tb/tb_nrisc_bus_bridge.sv
// Directed bench for nrisc_bus_bridge: vector table plus reset, ignore, early-ack, back-to-back and timeout sequences.
module tb_nrisc_bus_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  BRIDGE_addr;
  logic [15:0] BRIDGE_wdata;
  logic        BRIDGE_start_wr;
  logic        BRIDGE_start_rd;
  logic [15:0] BRIDGE_rdata;
  logic        BRIDGE_busy;
  logic        BRIDGE_done;
  logic        BRIDGE_err;
  logic [7:0]  PBUS_addr;
  logic [15:0] PBUS_wdata;
  logic        PBUS_we;
  logic        PBUS_req;
  logic        PBUS_ack;
  logic [15:0] PBUS_rdata;

  nrisc_bus_bridge #(.N_DData(8), .TAM(16), .TIMEOUT(32)) dut (
    .clk(clk), .rst(rst),
    .BRIDGE_addr(BRIDGE_addr), .BRIDGE_wdata(BRIDGE_wdata),
    .BRIDGE_start_wr(BRIDGE_start_wr), .BRIDGE_start_rd(BRIDGE_start_rd),
    .BRIDGE_rdata(BRIDGE_rdata), .BRIDGE_busy(BRIDGE_busy),
    .BRIDGE_done(BRIDGE_done), .BRIDGE_err(BRIDGE_err),
    .PBUS_addr(PBUS_addr), .PBUS_wdata(PBUS_wdata), .PBUS_we(PBUS_we),
    .PBUS_req(PBUS_req), .PBUS_ack(PBUS_ack), .PBUS_rdata(PBUS_rdata)
  );

  always #5 clk = ~clk;

  // Peripheral model: ack after acc_wait extra negedges of req, drops rel_wait negedges after req falls.
  int          acc_wait = 1;
  int          rel_wait = 1;
  logic [15:0] rd_val   = 16'h0000;
  logic        no_ack   = 1'b0;
  logic        hold_ack = 1'b0;

  initial begin
    int pc;
    pc = 0;
    PBUS_ack   = 1'b0;
    PBUS_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      if (hold_ack) begin
        PBUS_ack = 1'b1; PBUS_rdata = rd_val; pc = 0;
      end else if (!PBUS_ack) begin
        if (PBUS_req && !no_ack) begin
          if (pc >= acc_wait) begin
            PBUS_ack = 1'b1; PBUS_rdata = rd_val; pc = 0;
          end else pc++;
        end else pc = 0;
      end else if (!PBUS_req) begin
        if (pc >= rel_wait) begin
          PBUS_ack = 1'b0; pc = 0;
        end else pc++;
      end
    end
  end

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  typedef struct {
    logic        wr;
    logic        rd;
    logic [7:0]  addr;
    logic [15:0] wdata;
    int          wait_c;
    logic [15:0] prdata;
    logic        exp_we;
    int          exp_busy;
    logic [15:0] exp_rdata;
  } vec_t;

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (BRIDGE_busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk({name, "_timeout"}, 32'(BRIDGE_busy), 32'd0);
  endtask

  task automatic run_xfer(input string name, input vec_t v);
    int n;
    acc_wait = v.wait_c;
    rd_val   = v.prdata;
    BRIDGE_start_wr = v.wr;
    BRIDGE_start_rd = v.rd;
    BRIDGE_addr     = v.addr;
    BRIDGE_wdata    = v.wdata;
    @(negedge clk);
    BRIDGE_start_wr = 1'b0;
    BRIDGE_start_rd = 1'b0;
    chk({name, "_req"},   32'(PBUS_req), 32'd1);
    chk({name, "_busy"},  32'(BRIDGE_busy), 32'd1);
    chk({name, "_addr"},  32'(PBUS_addr), 32'(v.addr));
    chk({name, "_wdata"}, 32'(PBUS_wdata), 32'(v.wdata));
    chk({name, "_we"},    32'(PBUS_we), 32'(v.exp_we));
    chk({name, "_errclr"}, 32'(BRIDGE_err), 32'd0);
    n = 1;
    forever begin
      @(negedge clk);
      if (!BRIDGE_busy || n >= 300) break;
      n++;
    end
    chk({name, "_busycyc"}, 32'(n), 32'(v.exp_busy));
    chk({name, "_done"}, 32'(BRIDGE_done), 32'd1);
    chk({name, "_rdata"}, 32'(BRIDGE_rdata), 32'(v.exp_rdata));
    @(negedge clk);
    chk({name, "_donedrop"}, 32'(BRIDGE_done), 32'd0);
  endtask

  vec_t vecs[5];

  initial begin
    int n, rises;
    logic prev_done, prev_req;
    vec_t v;

    vecs[0] = '{1'b1, 1'b0, 8'h12, 16'hBEEF, 1, 16'h0000, 1'b1, 4, 16'h0000};
    vecs[1] = '{1'b0, 1'b1, 8'h80, 16'h0000, 3, 16'h1234, 1'b0, 6, 16'h1234};
    vecs[2] = '{1'b1, 1'b1, 8'h34, 16'h5A5A, 1, 16'h7777, 1'b1, 4, 16'h1234};
    vecs[3] = '{1'b0, 1'b1, 8'hFF, 16'h0000, 1, 16'hA5C3, 1'b0, 4, 16'hA5C3};
    vecs[4] = '{1'b1, 1'b0, 8'h00, 16'h0001, 2, 16'h9999, 1'b1, 5, 16'hA5C3};

    rst = 1'b0;
    BRIDGE_addr = 8'h00; BRIDGE_wdata = 16'h0000;
    BRIDGE_start_wr = 1'b0; BRIDGE_start_rd = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req",   32'(PBUS_req), 32'd0);
    chk("rst_busy",  32'(BRIDGE_busy), 32'd0);
    chk("rst_done",  32'(BRIDGE_done), 32'd0);
    chk("rst_rdata", 32'(BRIDGE_rdata), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_xfer($sformatf("vec%0d", i), vecs[i]);
      @(negedge clk);
    end

    // Start_rd while busy must be ignored.
    no_ack = 1'b1; acc_wait = 1;
    BRIDGE_start_wr = 1'b1; BRIDGE_addr = 8'h21; BRIDGE_wdata = 16'h1111;
    @(negedge clk);
    BRIDGE_start_wr = 1'b0;
    repeat (2) @(negedge clk);
    BRIDGE_start_rd = 1'b1; BRIDGE_addr = 8'h99;
    @(negedge clk);
    BRIDGE_start_rd = 1'b0;
    chk("ign_addr", 32'(PBUS_addr), 32'h21);
    chk("ign_we",   32'(PBUS_we), 32'd1);
    no_ack = 1'b0;
    wait_idle("ign");
    rises = 0; prev_req = PBUS_req;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (PBUS_req && !prev_req) rises++;
      prev_req = PBUS_req;
    end
    chk("ign_noreq", 32'(rises), 32'd0);
    chk("ign_rdata", 32'(BRIDGE_rdata), 32'hA5C3);

    // Ack already high when req rises: completes at the first ACCESS edge.
    hold_ack = 1'b1; rd_val = 16'h4242;
    @(negedge clk);
    BRIDGE_start_rd = 1'b1; BRIDGE_addr = 8'h05;
    @(negedge clk);
    BRIDGE_start_rd = 1'b0;
    hold_ack = 1'b0;
    @(negedge clk);
    chk("early_req",   32'(PBUS_req), 32'd0);
    chk("early_rdata", 32'(BRIDGE_rdata), 32'h4242);
    wait_idle("early");
    chk("early_done", 32'(BRIDGE_done), 32'd1);
    @(negedge clk);

    // Back-to-back: start_wr held; each done must be followed by a new req.
    acc_wait = 1;
    BRIDGE_start_wr = 1'b1; BRIDGE_addr = 8'h44; BRIDGE_wdata = 16'hCAFE;
    prev_done = 1'b0; prev_req = 1'b0; rises = 0; n = 0;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      if (prev_done) begin
        chk("b2b_req_after_done", 32'(PBUS_req), 32'd1);
        n++;
      end
      if (PBUS_req && !prev_req) rises++;
      prev_done = BRIDGE_done;
      prev_req  = PBUS_req;
    end
    BRIDGE_start_wr = 1'b0;
    chk("b2b_rises", 32'(rises >= 4), 32'd1);
    chk("b2b_dones", 32'(n >= 3), 32'd1);
    wait_idle("b2b");
    repeat (2) @(negedge clk);

`ifdef NRISC_BUSBRIDGE_TIMEOUT_EN
    no_ack = 1'b1;
    BRIDGE_start_rd = 1'b1; BRIDGE_addr = 8'h66;
    @(negedge clk);
    BRIDGE_start_rd = 1'b0;
    n = 1;
    forever begin
      @(negedge clk);
      if (!PBUS_req || n >= 100) break;
      n++;
    end
    chk("to_reqcyc", 32'(n), 32'd32);
    chk("to_err",    32'(BRIDGE_err), 32'd1);
    chk("to_rdata",  32'(BRIDGE_rdata), 32'hFFFF);
    @(negedge clk);
    chk("to_done",   32'(BRIDGE_done), 32'd1);
    chk("to_busy",   32'(BRIDGE_busy), 32'd0);
    no_ack = 1'b0;
    @(negedge clk);
    v = '{1'b1, 1'b0, 8'h07, 16'h0F0F, 1, 16'h0000, 1'b1, 4, 16'hFFFF};
    run_xfer("to_clr", v);
`else
    no_ack = 1'b1;
    BRIDGE_start_rd = 1'b1; BRIDGE_addr = 8'h66;
    @(negedge clk);
    BRIDGE_start_rd = 1'b0;
    repeat (40) @(negedge clk);
    chk("noto_req", 32'(PBUS_req), 32'd1);
    chk("noto_err", 32'(BRIDGE_err), 32'd0);
    rd_val = 16'h5151;
    no_ack = 1'b0;
    wait_idle("noto");
    chk("noto_rdata", 32'(BRIDGE_rdata), 32'h5151);
`endif
    @(negedge clk);

    // Asynchronous reset in the middle of ACCESS.
    no_ack = 1'b1;
    BRIDGE_start_rd = 1'b1; BRIDGE_addr = 8'h3C; BRIDGE_wdata = 16'h2222;
    @(negedge clk);
    BRIDGE_start_rd = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_req",  32'(PBUS_req), 32'd0);
    chk("arst_busy", 32'(BRIDGE_busy), 32'd0);
    chk("arst_done", 32'(BRIDGE_done), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    no_ack = 1'b0;
    @(negedge clk);
    chk("post_addr",  32'(PBUS_addr), 32'd0);
    chk("post_wdata", 32'(PBUS_wdata), 32'd0);
    chk("post_we",    32'(PBUS_we), 32'd0);
    chk("post_rdata", 32'(BRIDGE_rdata), 32'd0);
    chk("post_err",   32'(BRIDGE_err), 32'd0);
    chk("post_req",   32'(PBUS_req), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
